// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions: RDID opcode, responder states
// and default JEDEC ID bytes.
package spi_flash_pkg;

    localparam logic [7:0] CMD_RDID     = 8'h9F;

    localparam logic [7:0] DEF_MFG_ID   = 8'h20;
    localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
    localparam logic [7:0] DEF_MEM_CAP  = 8'h15;

    localparam int         BIT_CNT_W    = 6;
    localparam logic [5:0] CNT_CMD_LAST = 6'd7;
    localparam logic [5:0] CNT_ID_END   = 6'd32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_ID_OUT,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, with a third
// stage so rising and falling edges can be detected.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain plus edge-detect history stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_rdid_responder.sv
// Flash-side SPI responder answering JEDEC RDID (0x9F) with
// three configurable ID bytes; all pins oversampled by clk.
module spi_rdid_responder
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] MFG_ID   = DEF_MFG_ID,
    parameter logic [7:0] MEM_TYPE = DEF_MEM_TYPE,
    parameter logic [7:0] MEM_CAP  = DEF_MEM_CAP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       chip_select,
    output logic       SPIMISO,
    output logic       miso_oe,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    output logic       rdid_done,
    output logic       busy
);

    logic w_sclk_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi_s;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;
    logic w_cs_s;
    logic w_cs_rise_unused;
    logic w_cs_fall;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (SPICLK),
        .o_sync (w_sclk_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (SPIMOSI),
        .o_sync (w_mosi_s),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (chip_select),
        .o_sync (w_cs_s),
        .o_rise (w_cs_rise_unused),
        .o_fall (w_cs_fall)
    );

    state_t                 r_state;
    state_t                 w_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [7:0]             r_cmd_sr;
    logic [23:0]            r_resp;
    logic                   r_done_seen;
    logic                   r_miso;
    logic                   r_oe;
    logic [7:0]             r_cmd_byte;
    logic                   r_cmd_valid;
    logic                   r_rdid_done;

    logic [7:0]             w_cmd_word;
    logic                   w_byte_done;

    assign w_cmd_word  = {r_cmd_sr[6:0], w_mosi_s};
    assign w_byte_done = (r_state == S_CMD) && !w_cs_s &&
                         w_sclk_rise && (r_bit_cnt == CNT_CMD_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; deselect overrides any SPICLK edge
    always_comb begin
        w_next = r_state;
        if (w_cs_s) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        w_next = S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_byte_done) begin
                        w_next = (w_cmd_word == CMD_RDID) ? S_ID_OUT
                                                          : S_IGNORE;
                    end
                end
                S_ID_OUT: w_next = S_ID_OUT;
                S_IGNORE: w_next = S_IGNORE;
            endcase
        end
    end

    // Command capture, ID shift-out, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_cmd_sr    <= 8'h00;
            r_resp      <= 24'h0;
            r_done_seen <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_cmd_byte  <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_rdid_done <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_rdid_done <= 1'b0;
            if (w_cs_s) begin
                r_miso <= 1'b0;
                r_oe   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_bit_cnt   <= '0;
                            r_done_seen <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd_sr  <= w_cmd_word;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (w_byte_done) begin
                            r_cmd_byte  <= w_cmd_word;
                            r_cmd_valid <= 1'b1;
                            r_resp      <= {MFG_ID, MEM_TYPE, MEM_CAP};
                            r_oe        <= (w_cmd_word == CMD_RDID);
                        end
                    end
                    S_ID_OUT: begin
                        if (w_sclk_fall) begin
                            if (r_bit_cnt < CNT_ID_END) begin
                                r_miso    <= r_resp[23];
                                r_resp    <= {r_resp[22:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end else begin
                                r_miso <= 1'b0;
                                if (!r_done_seen) begin
                                    r_rdid_done <= 1'b1;
                                    r_done_seen <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                        r_oe   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SPIMISO   = r_miso;
    assign miso_oe   = r_oe;
    assign cmd_byte  = r_cmd_byte;
    assign cmd_valid = r_cmd_valid;
    assign rdid_done = r_rdid_done;
    assign busy      = ~w_cs_s;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Directed bench for spi_rdid_responder: a default-ID and an
// overridden-ID instance share one emulated SPI master.
module tb_spi_rdid_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;

    logic       miso_a, oe_a, cv_a, done_a, busy_a;
    logic [7:0] cb_a;
    logic       miso_b, oe_b, cv_b, done_b, busy_b;
    logic [7:0] cb_b;

    int n_checks = 0;
    int n_fail   = 0;

    int n_cv_a = 0, n_cv_b = 0;
    int n_dn_a = 0, n_dn_b = 0;
    int n_oe_a = 0, n_oe_b = 0;
    int n_bad_a = 0, n_bad_b = 0;

    always #5 clk = ~clk;

    spi_rdid_responder u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .SPICLK      (sclk),
        .SPIMOSI     (mosi),
        .chip_select (cs_n),
        .SPIMISO     (miso_a),
        .miso_oe     (oe_a),
        .cmd_byte    (cb_a),
        .cmd_valid   (cv_a),
        .rdid_done   (done_a),
        .busy        (busy_a)
    );

    spi_rdid_responder #(
        .MFG_ID   (8'hEF),
        .MEM_TYPE (8'h40),
        .MEM_CAP  (8'h17)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .SPICLK      (sclk),
        .SPIMOSI     (mosi),
        .chip_select (cs_n),
        .SPIMISO     (miso_b),
        .miso_oe     (oe_b),
        .cmd_byte    (cb_b),
        .cmd_valid   (cv_b),
        .rdid_done   (done_b),
        .busy        (busy_b)
    );

    // Event counters sampled away from the active edge
    always @(negedge clk) begin
        if (cv_a)           n_cv_a++;
        if (cv_b)           n_cv_b++;
        if (done_a)         n_dn_a++;
        if (done_b)         n_dn_b++;
        if (oe_a)           n_oe_a++;
        if (oe_b)           n_oe_b++;
        if (miso_a && !oe_a) n_bad_a++;
        if (miso_b && !oe_b) n_bad_b++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            mosi = c[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic read_bits(input int n,
                             output logic [31:0] ra,
                             output logic [31:0] rb);
        ra = '0;
        rb = '0;
        for (int j = 0; j < n; j++) begin
            repeat (4) @(negedge clk);
            ra = {ra[30:0], miso_a};
            rb = {rb[30:0], miso_b};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic release_cs();
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          nrd;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          exp_done;
    } vec_t;

    vec_t vecs [5];

    logic [31:0] ra, rb;
    int s_cv_a, s_cv_b, s_dn_a, s_dn_b, s_oe_a, s_oe_b;

    task automatic snap();
        s_cv_a = n_cv_a; s_cv_b = n_cv_b;
        s_dn_a = n_dn_a; s_dn_b = n_dn_b;
        s_oe_a = n_oe_a; s_oe_b = n_oe_b;
    endtask

    initial begin
        vecs[0] = '{8'h9F, 24, 32'h0020_2015, 32'h00EF_4017, 1};
        vecs[1] = '{8'h05, 24, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[2] = '{8'h9F, 32, 32'h2020_1500, 32'hEF40_1700, 1};
        vecs[3] = '{8'h9E, 24, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[4] = '{8'hF9, 24, 32'h0000_0000, 32'h0000_0000, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_miso",  {31'd0, miso_a}, 32'd0);
        chk("rst_oe",    {31'd0, oe_a},   32'd0);
        chk("rst_cmdb",  {24'd0, cb_a},   32'd0);
        chk("rst_cv",    {31'd0, cv_a},   32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven transactions
        for (int v = 0; v < 5; v++) begin
            snap();
            send_cmd(vecs[v].cmd);
            chk($sformatf("v%0d_busy", v), {31'd0, busy_a}, 32'd1);
            read_bits(vecs[v].nrd, ra, rb);
            release_cs();
            chk($sformatf("v%0d_rx_a", v), ra, vecs[v].exp_a);
            chk($sformatf("v%0d_rx_b", v), rb, vecs[v].exp_b);
            chk($sformatf("v%0d_cv_a", v), n_cv_a - s_cv_a, 1);
            chk($sformatf("v%0d_cv_b", v), n_cv_b - s_cv_b, 1);
            chk($sformatf("v%0d_cmdb", v), {24'd0, cb_a},
                {24'd0, vecs[v].cmd});
            chk($sformatf("v%0d_dn_a", v), n_dn_a - s_dn_a,
                vecs[v].exp_done);
            chk($sformatf("v%0d_dn_b", v), n_dn_b - s_dn_b,
                vecs[v].exp_done);
            chk($sformatf("v%0d_oe_a", v),
                {31'd0, (n_oe_a - s_oe_a) > 0}, vecs[v].exp_done);
            chk($sformatf("v%0d_idle_oe", v), {31'd0, oe_a}, 32'd0);
        end
        chk("miso_no_oe_a", n_bad_a, 0);
        chk("miso_no_oe_b", n_bad_b, 0);

        // Deselect after 12 response bits
        snap();
        send_cmd(8'h9F);
        read_bits(12, ra, rb);
        chk("desel_bits_a", ra, 32'h0000_0202);
        chk("desel_bits_b", rb, 32'h0000_0EF4);
        chk("desel_oe_pre", {31'd0, oe_a}, 32'd1);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("desel_oe",   {31'd0, oe_a},   32'd0);
        chk("desel_busy", {31'd0, busy_a}, 32'd0);
        chk("desel_miso", {31'd0, miso_a}, 32'd0);
        repeat (8) @(negedge clk);
        chk("desel_done", n_dn_a - s_dn_a, 0);

        snap();
        send_cmd(8'h9F);
        read_bits(24, ra, rb);
        release_cs();
        chk("after_desel_a", ra, 32'h0020_2015);
        chk("after_desel_dn", n_dn_a - s_dn_a, 1);

        // Async reset in the middle of a command byte
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 7; i >= 4; i--) begin
            mosi = (i == 7 || i == 4) ? 1'b1 : 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("prerst_busy", {31'd0, busy_a}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_cmdb", {24'd0, cb_a},   32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_cv",   {31'd0, cv_a},   32'd0);
        chk("midrst_oe",   {31'd0, oe_a},   32'd0);
        cs_n = 1'b1;
        mosi = 1'b0;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        snap();
        send_cmd(8'h9F);
        read_bits(24, ra, rb);
        release_cs();
        chk("post_rst_a", ra, 32'h0020_2015);
        chk("post_rst_b", rb, 32'h00EF_4017);
        chk("post_rst_cv", n_cv_a - s_cv_a, 1);
        chk("post_rst_dn", n_dn_a - s_dn_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rdid_responder.md
# spi_rdid_responder

Flash-side SPI responder that answers the JEDEC Read-Identification command (0x9F) with three configurable ID bytes. It lets the RDID master be exercised on-board and in simulation without a real SPI flash. All SPI pins are oversampled in the system clock domain. The block sits where the flash would: driven by the master's SPICLK, SPIMOSI and chip_select, and returning SPIMISO.

## Interface
Parameters:
- MFG_ID, 8'h20, manufacturer ID (byte 1 returned)
- MEM_TYPE, 8'h20, memory type (byte 2 returned)
- MEM_CAP, 8'h15, memory capacity (byte 3 returned)

Ports:
- clk  input  1  system clock; one clock domain; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- SPICLK  input  1  SPI clock from master, mode 0 (idle low), asynchronous to clk
- SPIMOSI  input  1  command data from master, MSB first
- chip_select  input  1  active-low select, asynchronous to clk
- SPIMISO  output  1  response data, MSB first
- miso_oe  output  1  high while the responder drives SPIMISO (ID phase only)
- cmd_byte  output  8  last complete command byte received
- cmd_valid  output  1  one-cycle pulse when a command byte completes
- rdid_done  output  1  one-cycle pulse after the 24th response bit has been shifted out
- busy  output  1  high whenever chip_select is sampled low

## Operation
- SPICLK, SPIMOSI and chip_select each pass through a 2-FF synchronizer; SPICLK rise/fall is detected from the 2nd and a 3rd stage.
- States: IDLE, CMD, ID_OUT, IGNORE.
- IDLE: synced chip_select falls -> CMD; bit counter cleared.
- CMD: on each SPICLK rise, shift synced SPIMOSI into an 8-bit register. On the 8th rise: load cmd_byte, pulse cmd_valid. If byte == 8'h9F -> ID_OUT, else -> IGNORE.
- ID_OUT: 24-bit response register = {MFG_ID, MEM_TYPE, MEM_CAP}. SPIMISO = bit 23 after the 8th SPICLK fall. Each later fall shifts left by one. After the 32nd fall (the 24th data bit has been presented and sampled), pulse rdid_done. After that, SPIMISO = 0 until deselect. miso_oe = 1 throughout ID_OUT.
- IGNORE: SPIMISO = 0, miso_oe = 0; SPICLK activity ignored until deselect.
- Synced chip_select high in any state -> IDLE the next cycle. Partial bytes are discarded; no cmd_valid or rdid_done. SPIMISO = 0, miso_oe = 0.
- One transaction per chip_select low period; no command chaining.
- Bit counter: 6 bits, saturating at 32.

## Timing
- Reset values: SPIMISO 0, miso_oe 0, cmd_byte 8'h00, cmd_valid 0, rdid_done 0, busy 0; state IDLE; all synchronizers 0, chip_select syncs 1.
- Edge latency: a pin transition is acted on exactly 3 clk cycles after it is first captured. SPIMISO and miso_oe are registered and change on that cycle.
- Constraint: SPICLK high and low times are each >= 4 clk periods, so SPIMISO is stable at least 1 clk before the master's next sampling rise. Chip_select setup to the first SPICLK rise is >= 4 clk.
- cmd_valid and the ID_OUT entry occur in the same cycle. rdid_done is registered in the cycle the 32nd fall is detected.
- Simultaneous deselect and SPICLK edge: deselect wins; the edge is ignored.
- Reset mid-transaction: immediate return to reset values. The block responds to the next chip_select fall.

## Structure
- Shared package spi_flash_pkg: CMD_RDID = 8'h9F, the state enum, and the default ID constants (also used by the master's testbench).
- One sub-module, spi_pin_sync: 2-FF sync plus rise/fall detect for a single pin, instantiated three times.
- Top module: FSM, bit counter, shift registers.

## Test plan
- RDID, defaults: 0x9F with SPICLK = clk/8 -> master reads 0x20, 0x20, 0x15; cmd_valid once with cmd_byte 0x9F; rdid_done once.
- Override parameters to 8'hEF/8'h40/8'h17 -> master reads 0xEF, 0x40, 0x17.
- Non-RDID command 0x05 -> cmd_valid with cmd_byte 0x05; miso_oe stays 0; SPIMISO 0 for 24 clocks; no rdid_done.
- Deselect after 12 response bits -> IDLE within 3 clk, miso_oe 0, no rdid_done. A following full RDID returns correct bytes.
- Async reset asserted mid-byte during CMD -> all outputs at reset values in the same cycle. The next RDID succeeds.
- Extra 8 SPICLKs after the third byte -> SPIMISO reads 0x00; rdid_done is not repeated.
